dmem_arbiter: RTL and testbench

//  Shares one data-memory port (in front of the L1 block_delay) between the scalar core and the vector unit.

---
 rtl/dmem_arb_pkg.sv | 36 +++
 rtl/dmem_arbiter_if.sv | 26 ++
 rtl/dmem_owner_fifo.sv | 55 +++++
 rtl/dmem_arbiter.sv | 90 +++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: request/response structs,
// owner tags and default parameter values.
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_VEC  = 1'b1
  } dmem_owner_t;

  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_STARVE_LIMIT    = 8;
  localparam bit DEF_WRITE_RSP       = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        do_read;
    logic        do_write;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } memory_io_rsp;

  localparam memory_io_req memory_io_no_req = '0;
  localparam memory_io_rsp memory_io_no_rsp = '0;

  // A granted request occupies an owner slot only if a response will come back.
  function automatic logic needs_rsp(memory_io_req r, bit write_rsp);
    return r.do_read || (write_rsp && r.do_write);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory path.
// Requests are valid-qualified; a request is taken in the cycle its gnt is 1,
// otherwise the requester holds it unchanged. Responses carry their own valid
// and are never back-pressured.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  memory_io_req core_req;
  logic         core_gnt;
  memory_io_rsp core_rsp;
  memory_io_req vec_req;
  logic         vec_gnt;
  memory_io_rsp vec_rsp;
  memory_io_req mem_req;
  memory_io_rsp mem_rsp;

  modport slave (
    input  core_req, vec_req, mem_rsp,
    output core_gnt, core_rsp, vec_gnt, vec_rsp, mem_req
  );

  modport master (
    output core_req, vec_req, mem_rsp,
    input  core_gnt, core_rsp, vec_gnt, vec_rsp, mem_req
  );
endinterface

// File: rtl/dmem_owner_fifo.sv
// One-bit in-order FIFO recording which requester owns each outstanding
// memory request. Supports push and pop in the same cycle, even when full.
module dmem_owner_fifo
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTSTANDING
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  dmem_owner_t              i_push_data,
  input  logic                     i_pop,
  output dmem_owner_t              o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  dmem_owner_t     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= OWN_CORE;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the scalar core and the vector unit,
// tracking request owners in order so responses return to their issuer.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT,
  parameter bit WRITE_RSP       = DEF_WRITE_RSP
) (
  input  logic                               clk,
  input  logic                               reset,
  dmem_arbiter_if.slave                      bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   inflight,
  output logic                               rsp_orphan,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]  dbg_starve_cnt
);
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  logic [SCW-1:0]  r_starve_cnt;
  logic            r_orphan;
  logic            w_pop;
  logic            w_push;
  logic            w_can_issue;
  logic            w_vec_forced;
  logic            w_core_gnt;
  logic            w_vec_gnt;
  logic            w_full;
  logic            w_empty;
  dmem_owner_t     w_head;
  dmem_owner_t     w_push_owner;
  memory_io_req    w_sel_req;

  always_comb begin
    w_pop        = bus.mem_rsp.valid && !w_empty;
    w_can_issue  = !w_full || w_pop;
    w_vec_forced = (r_starve_cnt == SCW'(STARVE_LIMIT));
    w_core_gnt   = w_can_issue && bus.core_req.valid
                   && !(bus.vec_req.valid && w_vec_forced);
    w_vec_gnt    = w_can_issue && bus.vec_req.valid && !w_core_gnt;
    w_sel_req    = memory_io_no_req;
    if (w_core_gnt)     w_sel_req = bus.core_req;
    else if (w_vec_gnt) w_sel_req = bus.vec_req;
    w_push       = (w_core_gnt || w_vec_gnt) && needs_rsp(w_sel_req, WRITE_RSP);
    w_push_owner = w_vec_gnt ? OWN_VEC : OWN_CORE;
  end

  // Responses arrive in issue order, so the FIFO head always names the owner.
  always_comb begin
    bus.core_gnt = w_core_gnt;
    bus.vec_gnt  = w_vec_gnt;
    bus.mem_req  = w_sel_req;
    bus.core_rsp = memory_io_no_rsp;
    bus.vec_rsp  = memory_io_no_rsp;
    if (w_pop) begin
      if (w_head == OWN_VEC) bus.vec_rsp  = bus.mem_rsp;
      else                   bus.core_rsp = bus.mem_rsp;
    end
  end

  dmem_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_owner),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (inflight)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_orphan     <= 1'b0;
    end else begin
      if (!bus.vec_req.valid || w_vec_gnt)
        r_starve_cnt <= '0;
      else if (w_core_gnt && !w_vec_forced)
        r_starve_cnt <= r_starve_cnt + SCW'(1);
      if (bus.mem_rsp.valid && w_empty)
        r_orphan <= 1'b1;
    end
  end

  assign rsp_orphan     = r_orphan;
  assign dbg_starve_cnt = r_starve_cnt;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour
// and hand-written sequences for starvation, write-response and reset cases.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus1 ();
  dmem_arbiter_if bus2 ();
  logic [2:0] inflight1, inflight2;
  logic       orphan1, orphan2;
  logic [3:0] starve1, starve2;

  dmem_arbiter u_dut (
    .clk (clk), .reset (reset), .bus (bus1.slave),
    .inflight (inflight1), .rsp_orphan (orphan1), .dbg_starve_cnt (starve1)
  );

  dmem_arbiter #(.WRITE_RSP (1'b0)) u_dut_nowr (
    .clk (clk), .reset (reset), .bus (bus2.slave),
    .inflight (inflight2), .rsp_orphan (orphan2), .dbg_starve_cnt (starve2)
  );

  typedef struct {
    logic        cv, cr, cw;
    logic [31:0] ca;
    logic        vv;
    logic [31:0] va;
    logic        rv;
    logic [31:0] rd;
    logic        e_cg, e_vg, e_mv;
    logic [31:0] e_ma;
    logic        e_crv, e_vrv;
    logic [31:0] e_rd;
    logic [2:0]  e_inf;
  } vec_t;

  vec_t tv[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic memory_io_req mk_req(logic v, logic r, logic w, logic [31:0] a);
    memory_io_req q;
    q = '{valid: v, do_read: r, do_write: w, be: 4'hf, addr: a, wdata: 32'h0};
    return q;
  endfunction

  function automatic memory_io_rsp mk_rsp(logic v, logic [31:0] d);
    memory_io_rsp q;
    q = '{valid: v, rdata: d};
    return q;
  endfunction

  function automatic vec_t mk(logic cv, logic cr, logic cw, logic [31:0] ca,
                              logic vv, logic [31:0] va, logic rv, logic [31:0] rd,
                              logic ecg, logic evg, logic emv, logic [31:0] ema,
                              logic ecrv, logic evrv, logic [31:0] erd, logic [2:0] einf);
    vec_t t;
    t = '{cv: cv, cr: cr, cw: cw, ca: ca, vv: vv, va: va, rv: rv, rd: rd,
          e_cg: ecg, e_vg: evg, e_mv: emv, e_ma: ema,
          e_crv: ecrv, e_vrv: evrv, e_rd: erd, e_inf: einf};
    return t;
  endfunction

  task automatic apply(input vec_t t);
    bus1.core_req = mk_req(t.cv, t.cr, t.cw, t.ca);
    bus1.vec_req  = mk_req(t.vv, 1'b1, 1'b0, t.va);
    bus1.mem_rsp  = mk_rsp(t.rv, t.rd);
  endtask

  task automatic idle1();
    bus1.core_req = memory_io_no_req;
    bus1.vec_req  = memory_io_no_req;
    bus1.mem_rsp  = memory_io_no_rsp;
  endtask

  task automatic idle2();
    bus2.core_req = memory_io_no_req;
    bus2.vec_req  = memory_io_no_req;
    bus2.mem_rsp  = memory_io_no_rsp;
  endtask

  initial begin
    idle1();
    idle2();

    // Core read alone at 0x1_0000, response three cycles later
    tv.push_back(mk(1,1,0,32'h0001_0000, 0,0, 0,0, 1,0,1,32'h0001_0000, 0,0,0, 3'd1));
    tv.push_back(mk(0,0,0,0,             0,0, 0,0, 0,0,0,0,             0,0,0, 3'd1));
    tv.push_back(mk(0,0,0,0,             0,0, 0,0, 0,0,0,0,             0,0,0, 3'd1));
    tv.push_back(mk(0,0,0,0,             0,0, 1,32'hCAFE_0001, 0,0,0,0, 1,0,32'hCAFE_0001, 3'd0));
    // Interleaved C,V,V,C reads, responses tagged 1..4
    tv.push_back(mk(1,1,0,32'h100, 0,0,       0,0, 1,0,1,32'h100, 0,0,0, 3'd1));
    tv.push_back(mk(0,0,0,0,       1,32'h200, 0,0, 0,1,1,32'h200, 0,0,0, 3'd2));
    tv.push_back(mk(0,0,0,0,       1,32'h204, 0,0, 0,1,1,32'h204, 0,0,0, 3'd3));
    tv.push_back(mk(1,1,0,32'h104, 0,0,       0,0, 1,0,1,32'h104, 0,0,0, 3'd4));
    tv.push_back(mk(0,0,0,0, 0,0, 1,32'd1, 0,0,0,0, 1,0,32'd1, 3'd3));
    tv.push_back(mk(0,0,0,0, 0,0, 1,32'd2, 0,0,0,0, 0,1,32'd2, 3'd2));
    tv.push_back(mk(0,0,0,0, 0,0, 1,32'd3, 0,0,0,0, 0,1,32'd3, 3'd1));
    tv.push_back(mk(0,0,0,0, 0,0, 1,32'd4, 0,0,0,0, 1,0,32'd4, 3'd0));
    // Fill to MAX_OUTSTANDING, blocked 5th, then response-enabled grant while full
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(1,1,0,32'h400 + 32'(i), 0,0, 0,0, 1,0,1,32'h400 + 32'(i), 0,0,0, 3'(i+1)));
    tv.push_back(mk(1,1,0,32'h404, 0,0, 0,0,         0,0,0,0,         0,0,0, 3'd4));
    tv.push_back(mk(1,1,0,32'h404, 0,0, 1,32'h11,    1,0,1,32'h404,   1,0,32'h11, 3'd4));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0,0,0,0, 0,0, 1,32'h12 + 32'(i), 0,0,0,0, 1,0,32'h12 + 32'(i), 3'(3-i)));
    // Request with neither read nor write: granted, no slot used
    tv.push_back(mk(1,0,0,32'h500, 0,0, 0,0, 1,0,1,32'h500, 0,0,0, 3'd0));
    // Vector alone, then its response
    tv.push_back(mk(0,0,0,0, 1,32'h600, 0,0,         0,1,1,32'h600, 0,0,0, 3'd1));
    tv.push_back(mk(0,0,0,0, 0,0,       1,32'h77,    0,0,0,0,       0,1,32'h77, 3'd0));

    // Reset state
    #2;
    chk("reset inflight", 32'(inflight1), 32'd0);
    chk("reset orphan",   32'(orphan1),   32'd0);
    chk("reset starve",   32'(starve1),   32'd0);
    chk("reset mem_req",  32'(bus1.mem_req.valid), 32'd0);
    chk("reset gnt",      32'({bus1.core_gnt, bus1.vec_gnt}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      apply(tv[i]);
      #2;
      chk($sformatf("row%0d core_gnt", i), 32'(bus1.core_gnt), 32'(tv[i].e_cg));
      chk($sformatf("row%0d vec_gnt", i),  32'(bus1.vec_gnt),  32'(tv[i].e_vg));
      chk($sformatf("row%0d mem_valid", i), 32'(bus1.mem_req.valid), 32'(tv[i].e_mv));
      if (tv[i].e_mv) chk($sformatf("row%0d mem_addr", i), bus1.mem_req.addr, tv[i].e_ma);
      chk($sformatf("row%0d core_rsp_v", i), 32'(bus1.core_rsp.valid), 32'(tv[i].e_crv));
      chk($sformatf("row%0d vec_rsp_v", i),  32'(bus1.vec_rsp.valid),  32'(tv[i].e_vrv));
      if (tv[i].e_crv) chk($sformatf("row%0d core_rdata", i), bus1.core_rsp.rdata, tv[i].e_rd);
      if (tv[i].e_vrv) chk($sformatf("row%0d vec_rdata", i),  bus1.vec_rsp.rdata,  tv[i].e_rd);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d inflight", i), 32'(inflight1), 32'(tv[i].e_inf));
    end

    // Starvation: both request every cycle, one response per cycle from cycle 1
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus1.core_req = mk_req(1'b1, 1'b1, 1'b0, 32'h700);
      bus1.vec_req  = mk_req(1'b1, 1'b1, 1'b0, 32'h800);
      bus1.mem_rsp  = mk_rsp(i > 0, 32'(i));
      #2;
      chk($sformatf("starve%0d core_gnt", i), 32'(bus1.core_gnt), 32'(i < 8));
      chk($sformatf("starve%0d vec_gnt", i),  32'(bus1.vec_gnt),  32'(i == 8));
      chk($sformatf("starve%0d cnt", i),      32'(starve1),       32'(i));
      chk($sformatf("starve%0d mem_addr", i), bus1.mem_req.addr, (i == 8) ? 32'h800 : 32'h700);
      if (i > 0) chk($sformatf("starve%0d core_rsp", i), 32'(bus1.core_rsp.valid), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("starve%0d inflight", i), 32'(inflight1), 32'd1);
    end
    chk("starve cleared", 32'(starve1), 32'd0);
    @(negedge clk);
    idle1();
    bus1.mem_rsp = mk_rsp(1'b1, 32'h99);
    #2;
    chk("starve drain vec_rsp", 32'(bus1.vec_rsp.valid), 32'd1);
    chk("starve drain core_rsp", 32'(bus1.core_rsp.valid), 32'd0);
    chk("starve drain data", bus1.vec_rsp.rdata, 32'h99);
    @(posedge clk);
    #1;
    chk("starve drain inflight", 32'(inflight1), 32'd0);

    // WRITE_RSP=0 instance: write uses no slot, the read does
    @(negedge clk);
    idle1();
    bus2.core_req = mk_req(1'b1, 1'b0, 1'b1, 32'h40);
    #2;
    chk("nowr write gnt", 32'(bus2.core_gnt), 32'd1);
    @(posedge clk);
    #1;
    chk("nowr after write", 32'(inflight2), 32'd0);
    @(negedge clk);
    bus2.core_req = mk_req(1'b1, 1'b1, 1'b0, 32'h44);
    @(posedge clk);
    #1;
    chk("nowr after read", 32'(inflight2), 32'd1);
    @(negedge clk);
    idle2();
    bus2.mem_rsp = mk_rsp(1'b1, 32'h55);
    #2;
    chk("nowr core_rsp", 32'(bus2.core_rsp.valid), 32'd1);
    chk("nowr vec_rsp",  32'(bus2.vec_rsp.valid),  32'd0);
    chk("nowr rdata",    bus2.core_rsp.rdata,      32'h55);
    @(posedge clk);
    #1;
    chk("nowr drained", 32'(inflight2), 32'd0);
    chk("nowr orphan",  32'(orphan2),   32'd0);

    // Orphan response with empty FIFO
    @(negedge clk);
    idle2();
    bus1.mem_rsp = mk_rsp(1'b1, 32'hDEAD);
    #2;
    chk("orphan core_rsp", 32'(bus1.core_rsp.valid), 32'd0);
    chk("orphan vec_rsp",  32'(bus1.vec_rsp.valid),  32'd0);
    @(posedge clk);
    #1;
    chk("orphan set", 32'(orphan1), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus1.mem_rsp  = memory_io_no_rsp;
      bus1.core_req = mk_req(1'b1, 1'b1, 1'b0, 32'h900 + 32'(i));
    end
    @(posedge clk);
    #1;
    chk("orphan sticky", 32'(orphan1), 32'd1);
    chk("pre-reset inflight", 32'(inflight1), 32'd2);
    @(negedge clk);
    idle1();
    #2;
    reset = 1'b1;
    #1;
    chk("async reset inflight", 32'(inflight1), 32'd0);
    chk("async reset orphan",   32'(orphan1),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset inflight", 32'(inflight1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
